// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the register file with scoreboard: default
// geometry derived from the machine word size, the default register
// address type, and the helper that locates a read port's field inside
// the packed rd_addr / rd_data buses.
package regfile_sb_pkg;

    localparam int WORD_SIZE    = 16;
    localparam int DEF_WIDTH    = WORD_SIZE;
    localparam int DEF_NUM_REGS = WORD_SIZE / 4;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

    // Read port k occupies bits [k*field_w +: field_w] of a packed port bus.
    function automatic int rd_lsb(input int port, input int field_w);
        return port * field_w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Scoreboard for regfile_sb: one busy bit per architectural register.
// Within one edge, writeback clears first, allocate then sets (the new
// producer wins), and flush clears everything last. any_busy is a
// registered OR of the next-state busy vector.
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                alloc_en,
    input  logic [ADDR_W-1:0]   alloc_addr,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busy,
    output logic                any_busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                any_busy_q;
    logic                any_busy_d;

    // Next-state busy vector with writeback < alloc < flush priority.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (alloc_en) begin
            busy_d[alloc_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        any_busy_d = |busy_d;
    end

    // Busy state and summary flag; reset clears both immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q     <= '0;
            any_busy_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            any_busy_q <= any_busy_d;
        end
    end

    assign busy     = busy_q;
    assign any_busy = any_busy_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised multi-read-port register file with an
// integrated busy-bit scoreboard for hazard detection.
// Optional build macro REGFILE_BYPASS_EN: a same-cycle writeback is
// forwarded to any read port addressing it (data and busy).
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_RD*ADDR_W-1:0]       rd_addr,
    output logic signed [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic                           alloc_en,
    input  logic [ADDR_W-1:0]              alloc_addr,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic signed [WIDTH-1:0]        wr_data,
    input  logic                           flush,
    output logic                           any_busy
);

    logic signed [WIDTH-1:0] regs_q [NUM_REGS];
    logic signed [WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]     busy;

    // Writeback updates the addressed word; flush never touches data.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Data array; reset zeroes every register without a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .reset_n    (reset_n),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .flush      (flush),
        .busy       (busy),
        .any_busy   (any_busy)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        localparam int ALSB = rd_lsb(k, ADDR_W);
        localparam int DLSB = rd_lsb(k, WIDTH);

        logic [ADDR_W-1:0]       addr;
        logic signed [WIDTH-1:0] port_data;
        logic                    port_busy;

        assign addr = rd_addr[ALSB +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
        // Read mux with writeback forwarding; a same-edge re-allocation of
        // the written register keeps the port busy.
        always_comb begin
            port_data = regs_q[addr];
            port_busy = busy[addr];
            if (wr_en && (addr == wr_addr)) begin
                port_data = wr_data;
                port_busy = alloc_en && (alloc_addr == wr_addr);
            end
        end
`else
        // Plain read mux: only stored state is visible.
        always_comb begin
            port_data = regs_q[addr];
            port_busy = busy[addr];
        end
`endif

        assign rd_data[DLSB +: WIDTH] = port_data;
        assign rd_busy[k]             = port_busy;
    end

endmodule
